// File: rtl/park_release_ctrl_pkg.sv
// rtl/park_release_ctrl_pkg.sv - shared types and helpers for the in-order park release scheduler
package rob_pkg;

   // Internal UID width: row index bits followed by column index bits
   function automatic int uid_w(input int rows, input int cols);
      return $clog2(rows) + $clog2(cols);
   endfunction

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      SEND = 3'd2,
      FREE = 3'd3,
      WACK = 3'd4
   } rel_state_e;

   localparam int BEAT_DATA_W = 256;
   localparam int BEAT_RESP_W = 2;
   localparam int BEAT_ID_W   = 8;

   // One single-beat read response as copied out of the parking lot
   typedef struct packed {
      logic [BEAT_DATA_W-1:0] data;
      logic [BEAT_RESP_W-1:0] resp;
      logic [BEAT_ID_W-1:0]   id;
   } r_beat_t;

endpackage

// File: rtl/park_release_ctrl_if.sv
// rtl/park_release_ctrl_if.sv - issue/arrival/park/master signal bundle around the release scheduler
interface park_release_ctrl_if #(
   parameter int NUM_ROWS   = 4,
   parameter int NUM_COLS   = 4,
   parameter int DATA_WIDTH = 256,
   parameter int RESP_WIDTH = 2,
   parameter int ID_WIDTH   = 8
);
   import rob_pkg::*;

   localparam int UID_W = uid_w(NUM_ROWS, NUM_COLS);

   logic                  iss_valid;
   logic                  iss_ready;
   logic [UID_W-1:0]      iss_uid;
   logic                  arr_valid;
   logic [UID_W-1:0]      arr_uid;
   logic                  alloc_req;
   logic [UID_W-1:0]      alloc_uid;
   logic                  pk_valid;
   logic [DATA_WIDTH-1:0] pk_data;
   logic [RESP_WIDTH-1:0] pk_resp;
   logic [ID_WIDTH-1:0]   pk_id;
   logic                  free_req;
   logic [UID_W-1:0]      id_to_release;
   logic                  free_ack;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic [RESP_WIDTH-1:0] m_resp;
   logic [ID_WIDTH-1:0]   m_id;
   logic                  m_last;
   logic                  proto_err;
   logic                  timeout_err;

   // Scheduler side
   modport master (
      input  iss_valid, iss_uid, arr_valid, arr_uid, pk_valid, pk_data, pk_resp, pk_id,
             free_ack, m_ready,
      output iss_ready, alloc_req, alloc_uid, free_req, id_to_release, m_valid, m_data,
             m_resp, m_id, m_last, proto_err, timeout_err
   );

   // Remapper / parking lot / master side
   modport slave (
      output iss_valid, iss_uid, arr_valid, arr_uid, pk_valid, pk_data, pk_resp, pk_id,
             free_ack, m_ready,
      input  iss_ready, alloc_req, alloc_uid, free_req, id_to_release, m_valid, m_data,
             m_resp, m_id, m_last, proto_err, timeout_err
   );

endinterface

// File: rtl/park_release_ctrl_uid_order_fifo.sv
// rtl/park_release_ctrl_uid_order_fifo.sv - circular FIFO holding UIDs in issue order
module uid_order_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] head_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Pointer wrap at DEPTH-1 so non power-of-two depths also work; push+pop keeps count
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push_i) wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      if (pop_i)  rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: entries are only read when the count says they are valid
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q] <= data_i;
   end

   assign head_o  = mem_q[rd_q];
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/park_release_ctrl.sv
// rtl/park_release_ctrl.sv - in-order response release scheduler; optional watchdog under ROB_RELEASE_TIMEOUT_EN
module park_release_ctrl
   import rob_pkg::*;
#(
   parameter int NUM_ROWS        = 4,
   parameter int NUM_COLS        = 4,
   parameter int MAX_OUTSTANDING = NUM_ROWS * NUM_COLS,
   parameter int DATA_WIDTH      = 256,
   parameter int RESP_WIDTH      = 2,
   parameter int ID_WIDTH        = 8,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input logic                 clk,
   input logic                 rst,
   park_release_ctrl_if.master bus
);
   localparam int UID_W = uid_w(NUM_ROWS, NUM_COLS);

   // The watchdog counter is 16 bits wide and saturates, so the limit must fit in it
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES out of range");
   end

   rel_state_e state_q, state_d;

   logic [MAX_OUTSTANDING-1:0] busy_q, busy_d;
   logic [MAX_OUTSTANDING-1:0] arrived_q, arrived_d;
   logic                       proto_q, proto_d;
   logic [DATA_WIDTH-1:0]      data_q, data_d;
   logic [RESP_WIDTH-1:0]      resp_q, resp_d;
   logic [ID_WIDTH-1:0]        id_q, id_d;

   logic             push, pop, capture, tmo_exp;
   logic             fifo_full, fifo_empty;
   logic [UID_W-1:0] head;
   logic             dup_push, arr_bad, ack_bad;

   // iss_ready comes from the registered count only, so a pop never frees a slot the same cycle
   assign push = bus.iss_valid & ~fifo_full;

   uid_order_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .W     (UID_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  (bus.iss_uid),
      .pop_i   (pop),
      .head_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Busy/arrived bookkeeping and protocol checks; a bad arrival leaves the bitmap untouched
   always_comb begin
      busy_d    = busy_q;
      arrived_d = arrived_q;
      dup_push  = push & busy_q[bus.iss_uid];
      arr_bad   = bus.arr_valid & (~busy_q[bus.arr_uid] | arrived_q[bus.arr_uid]);
      ack_bad   = bus.free_ack & (state_q != WACK);
      if (bus.arr_valid && !arr_bad) arrived_d[bus.arr_uid] = 1'b1;
      if (pop) begin
         busy_d[head]    = 1'b0;
         arrived_d[head] = 1'b0;
      end
      if (push) busy_d[bus.iss_uid] = 1'b1;
      proto_d = proto_q | dup_push | arr_bad | ack_bad;
   end

   // Release FSM: wait for head arrival, fetch copy, present to master, free, await ack
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      pop     = 1'b0;
      case (state_q)
         IDLE: if (!fifo_empty && arrived_q[head]) state_d = REQ;
         REQ: begin
            if (bus.pk_valid) begin
               capture = 1'b1;
               state_d = SEND;
            end else if (tmo_exp) begin
               state_d = IDLE;
            end
         end
         SEND: if (bus.m_ready) state_d = FREE;
         FREE: state_d = WACK;
         WACK: begin
            if (bus.free_ack) begin
               pop     = 1'b1;
               state_d = IDLE;
            end else if (tmo_exp) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output beat register: loaded once per release, frozen while m_valid is high
   always_comb begin
      data_d = data_q;
      resp_d = resp_q;
      id_d   = id_q;
      if (capture) begin
         data_d = bus.pk_data;
         resp_d = bus.pk_resp;
         id_d   = bus.pk_id;
      end
   end

   // State, bitmap, error and payload registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         busy_q    <= '0;
         arrived_q <= '0;
         proto_q   <= 1'b0;
         data_q    <= '0;
         resp_q    <= '0;
         id_q      <= '0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         arrived_q <= arrived_d;
         proto_q   <= proto_d;
         data_q    <= data_d;
         resp_q    <= resp_d;
         id_q      <= id_d;
      end
   end

`ifdef ROB_RELEASE_TIMEOUT_EN
   localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] tmo_q, tmo_d;
   logic        tmo_err_q, tmo_err_d;

   // Watchdog: restarts on every state change, counts while waiting in REQ/WACK, saturates
   always_comb begin
      tmo_d = tmo_q;
      if (state_d != state_q) begin
         tmo_d = '0;
      end else if ((state_q == REQ || state_q == WACK) && tmo_q != 16'hFFFF) begin
         tmo_d = tmo_q + 16'd1;
      end
      // Leaving for IDLE without a pop can only be the watchdog firing
      tmo_err_d = tmo_err_q | (tmo_exp & (state_d == IDLE) & ~pop);
   end

   // Watchdog registers
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_q     <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         tmo_q     <= tmo_d;
         tmo_err_q <= tmo_err_d;
      end
   end

   assign tmo_exp         = (state_q == REQ || state_q == WACK) && (tmo_q >= TMO_LIMIT);
   assign bus.timeout_err = tmo_err_q;
`else
   assign tmo_exp         = 1'b0;
   assign bus.timeout_err = 1'b0;
`endif

   assign bus.iss_ready     = ~fifo_full;
   assign bus.alloc_req     = (state_q == REQ);
   assign bus.alloc_uid     = (state_q == REQ) ? head : '0;
   assign bus.free_req      = (state_q == FREE);
   assign bus.id_to_release = (state_q == FREE) ? head : '0;
   assign bus.m_valid       = (state_q == SEND);
   assign bus.m_data        = data_q;
   assign bus.m_resp        = resp_q;
   assign bus.m_id          = id_q;
   assign bus.m_last        = 1'b1;
   assign bus.proto_err     = proto_q;

endmodule

// File: tb/tb_park_release_ctrl.sv
// tb/tb_park_release_ctrl.sv - directed self-checking bench for park_release_ctrl
module tb_park_release_ctrl;

`ifdef ROB_RELEASE_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 1024;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   park_release_ctrl_if #(.NUM_ROWS(4), .NUM_COLS(4), .DATA_WIDTH(256), .RESP_WIDTH(2), .ID_WIDTH(8)) bus ();

   park_release_ctrl #(
      .NUM_ROWS(4), .NUM_COLS(4), .MAX_OUTSTANDING(16), .DATA_WIDTH(256),
      .RESP_WIDTH(2), .ID_WIDTH(8), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] exp_data(input logic [3:0] u);
      return {8{28'hDA7A000, u}};
   endfunction

   function automatic logic [7:0] exp_id(input logic [3:0] u);
      return {4'hA, u};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic issue(input logic [3:0] u);
      bus.iss_valid = 1'b1;
      bus.iss_uid   = u;
      tick();
      bus.iss_valid = 1'b0;
   endtask

   task automatic arrive(input logic [3:0] u);
      bus.arr_valid = 1'b1;
      bus.arr_uid   = u;
      tick();
      bus.arr_valid = 1'b0;
   endtask

   task automatic wait_alloc(input string tag);
      int n = 0;
      while (bus.alloc_req !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check({tag, "_alloc_seen"}, bus.alloc_req, 1'b1);
   endtask

   task automatic park_reply(input logic [3:0] u);
      bus.pk_valid = 1'b1;
      bus.pk_data  = exp_data(u);
      bus.pk_resp  = u[1:0];
      bus.pk_id    = exp_id(u);
      tick();
      bus.pk_valid = 1'b0;
      bus.pk_data  = '0;
      bus.pk_resp  = '0;
      bus.pk_id    = '0;
   endtask

   // Full release of head u with the master stalling for 'hold' cycles in SEND
   task automatic release_one(input logic [3:0] u, input int hold);
      logic stable;
      wait_alloc("rel");
      check("alloc_uid", bus.alloc_uid, u);
      park_reply(u);
      check("m_valid_up", bus.m_valid, 1'b1);
      check("alloc_drop", bus.alloc_req, 1'b0);
      check("m_id", bus.m_id, exp_id(u));
      check("m_data", bus.m_data, exp_data(u));
      check("m_resp", bus.m_resp, u[1:0]);
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         tick();
         if (bus.m_valid !== 1'b1 || bus.m_id !== exp_id(u) || bus.m_data !== exp_data(u) ||
             bus.free_req !== 1'b0)
            stable = 1'b0;
      end
      if (hold > 0) check("bp_stable", stable, 1'b1);
      bus.m_ready = 1'b1;
      tick();
      bus.m_ready = 1'b0;
      check("free_req", bus.free_req, 1'b1);
      check("free_id", bus.id_to_release, u);
      check("m_valid_drop", bus.m_valid, 1'b0);
      tick();
      check("free_one_cycle", bus.free_req, 1'b0);
      bus.free_ack = 1'b1;
      tick();
      bus.free_ack = 1'b0;
   endtask

   initial begin
      logic seen;
      int   n;
      bus.iss_valid = 0; bus.iss_uid = '0; bus.arr_valid = 0; bus.arr_uid = '0;
      bus.pk_valid = 0; bus.pk_data = '0; bus.pk_resp = '0; bus.pk_id = '0;
      bus.free_ack = 0; bus.m_ready = 0;
      tick();
      tick();
      check("rst_iss_ready", bus.iss_ready, 1'b1);
      check("rst_m_last", bus.m_last, 1'b1);
      check("rst_m_valid", bus.m_valid, 1'b0);
      check("rst_alloc", bus.alloc_req, 1'b0);
      check("rst_alloc_uid", bus.alloc_uid, 4'd0);
      check("rst_free", bus.free_req, 1'b0);
      check("rst_m_data", bus.m_data, 256'd0);
      check("rst_proto", bus.proto_err, 1'b0);
      check("rst_tmo", bus.timeout_err, 1'b0);
      rst = 1'b0;

      // In-order: issue 3 then 1, arrive 1 first; 3 must still go first
      issue(4'd3);
      issue(4'd1);
      arrive(4'd1);
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus.alloc_req !== 1'b0) seen = 1'b1;
      end
      check("no_early_alloc", seen, 1'b0);
      arrive(4'd3);
      check("arr_gap", bus.alloc_req, 1'b0);
      release_one(4'd3, 0);
      release_one(4'd1, 0);
      check("inorder_proto", bus.proto_err, 1'b0);

      // Backpressure for 10 cycles
      issue(4'd5);
      arrive(4'd5);
      release_one(4'd5, 10);

      // Fill all 16 slots
      for (int i = 0; i < 16; i++) begin
         bus.iss_valid = 1'b1;
         bus.iss_uid   = 4'(i);
         tick();
      end
      bus.iss_valid = 1'b0;
      check("full_ready", bus.iss_ready, 1'b0);
      check("full_proto", bus.proto_err, 1'b0);
      arrive(4'd0);
      check("full_ready_hold", bus.iss_ready, 1'b0);
      release_one(4'd0, 0);
      check("ready_after_pop", bus.iss_ready, 1'b1);

      // Reset while UID 1 sits in SEND
      arrive(4'd1);
      wait_alloc("rst_send");
      check("rst_send_uid", bus.alloc_uid, 4'd1);
      park_reply(4'd1);
      check("in_send", bus.m_valid, 1'b1);
      rst = 1'b1;
      tick();
      check("rst_send_m_valid", bus.m_valid, 1'b0);
      check("rst_send_ready", bus.iss_ready, 1'b1);
      check("rst_send_data", bus.m_data, 256'd0);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (bus.free_req !== 1'b0 || bus.alloc_req !== 1'b0) seen = 1'b1;
         tick();
      end
      check("rst_no_free", seen, 1'b0);
      issue(4'd2);
      arrive(4'd2);
      release_one(4'd2, 0);
      check("rst_clean_proto", bus.proto_err, 1'b0);

      // Arrival for unissued UID 7
      arrive(4'd7);
      check("arr_unissued", bus.proto_err, 1'b1);
      check("arr_unissued_idle", bus.alloc_req, 1'b0);
      issue(4'd7);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.alloc_req !== 1'b0) seen = 1'b1;
      end
      check("arr_bit_unchanged", seen, 1'b0);

      // Duplicate issue
      do_reset();
      check("proto_cleared", bus.proto_err, 1'b0);
      issue(4'd4);
      check("first_issue_ok", bus.proto_err, 1'b0);
      issue(4'd4);
      check("dup_issue", bus.proto_err, 1'b1);

      // Stray free_ack in IDLE
      do_reset();
      bus.free_ack = 1'b1;
      tick();
      bus.free_ack = 1'b0;
      check("stray_ack", bus.proto_err, 1'b1);

      do_reset();
      issue(4'd6);
      arrive(4'd6);
      wait_alloc("tmo");
`ifdef ROB_RELEASE_TIMEOUT_EN
      n = 0;
      while (bus.alloc_req === 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("tmo_req_cycles", 32'(n), 32'd8);
      check("tmo_err", bus.timeout_err, 1'b1);
      check("tmo_idle", bus.alloc_req, 1'b0);
      tick();
      check("tmo_retry", bus.alloc_req, 1'b1);
      check("tmo_retry_uid", bus.alloc_uid, 4'd6);
      release_one(4'd6, 0);
`else
      n = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.alloc_req === 1'b1) n++;
      end
      check("req_waits", 32'(n), 32'd20);
      check("no_tmo_err", bus.timeout_err, 1'b0);
      release_one(4'd6, 0);
`endif
      check("final_proto", bus.proto_err, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/park_release_ctrl.md
Name: park_release_ctrl

Overview:
- In-order release scheduler for the response parking lot.
- Records the issue order of internal UIDs from the remapper and tracks which UIDs have been parked.
- Releases the oldest UID only once it has arrived: issues allocate, captures the copied response, drives it to the master with valid/ready backpressure, then issues FREE and waits for the acknowledge.
- Sits between the parking lot and the master-facing R channel.

Parameters:
- NUM_ROWS, 4, UID row dimension.
- NUM_COLS, 4, UID column dimension; UID_W = $clog2(NUM_ROWS)+$clog2(NUM_COLS).
- MAX_OUTSTANDING, NUM_ROWS*NUM_COLS, order-FIFO depth and bitmap size.
- DATA_WIDTH, 256, RDATA width.
- RESP_WIDTH, 2, RRESP width.
- ID_WIDTH, 8, original master-facing ID width.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- iss_valid  in  1  remapper pushes a newly issued UID.
- iss_ready  out  1  order FIFO not full.
- iss_uid  in  UID_W  issued UID.
- arr_valid  in  1  park enqueue handshake occurred.
- arr_uid  in  UID_W  UID just parked.
- alloc_req  out  1  allocate request to park.
- alloc_uid  out  UID_W  UID being allocated (equals head).
- pk_valid  in  1  park output copy valid.
- pk_data  in  DATA_WIDTH  parked data.
- pk_resp  in  RESP_WIDTH  parked resp.
- pk_id  in  ID_WIDTH  original ID.
- free_req  out  1  FREE request to park.
- id_to_release  out  UID_W  UID to free.
- free_ack  in  1  park FREE acknowledge.
- m_valid  out  1  master R valid.
- m_ready  in  1  master R ready.
- m_data  out  DATA_WIDTH  master R data.
- m_resp  out  RESP_WIDTH  master R resp.
- m_id  out  ID_WIDTH  master R id.
- m_last  out  1  tied 1 (single beat).
- proto_err  out  1  sticky protocol error.
- timeout_err  out  1  sticky watchdog error.

Behaviour:
- Reset: FSM=IDLE, FIFO empty (pointers 0, count 0), all bitmaps 0, all outputs 0 except m_last=1 and iss_ready=1.
- Order FIFO: circular, MAX_OUTSTANDING entries. Wrap pointers at MAX_OUTSTANDING-1 → 0. Count width $clog2(MAX_OUTSTANDING)+1.
- Push on iss_valid&iss_ready. Push and pop in the same cycle are both honoured. At full with a same-cycle pop, iss_ready stays 0 (registered-count based, no bypass).
- Bitmaps:
  - busy[uid] set on push, cleared on pop.
  - arrived[uid] set on arr_valid; cleared on pop.
  - Push of a UID already busy → proto_err=1, push still accepted.
  - arr_valid for a UID not busy, or already arrived → proto_err=1, bit not changed.
- Arrival/head interaction: arr_valid for head in IDLE is visible next cycle. One-cycle minimum gap between arrival and alloc_req.
- FSM:
  - IDLE: if count≠0 & arrived[head] → REQ.
  - REQ: alloc_req=1, alloc_uid=head. On pk_valid, capture pk_data/resp/id into output register → SEND. alloc_req drops the same cycle.
  - SEND: m_valid=1, payload stable. On m_ready → FREE.
  - FREE: free_req=1 for exactly one cycle, id_to_release=head → WACK.
  - WACK: on free_ack, pop FIFO and clear busy/arrived[head] → IDLE.
  - free_ack in any other state → proto_err.
- Throughput: minimum 5 cycles per response (IDLE, REQ, SEND, FREE, WACK) when m_ready=1 and park responds immediately.
- m_valid is never deasserted without m_ready; payload does not change while m_valid=1.
- rst mid-operation: everything returns to reset values next edge. No FREE is issued for the in-flight UID; the park is reset together.

Optional Feature:
- ROB_RELEASE_TIMEOUT_EN defined:
  - A 16-bit counter runs in REQ and WACK and clears on entry to each state.
  - When it reaches TIMEOUT_CYCLES, set timeout_err (sticky) and go to IDLE without popping.
  - Head is retried; counter saturates, no wrap.
- Undefined: no counter; timeout_err tied 0; REQ and WACK wait indefinitely.

Decomposition:
- Package rob_pkg holds:
  - UID_W computation function.
  - rel_state_e enum {IDLE, REQ, SEND, FREE, WACK}.
  - Typedef r_beat_t {data, resp, id}.
- One natural sub-module: uid_order_fifo (circular FIFO with count and full/empty).

Test Plan:
- Basic in-order release: issue UIDs 3,1; arrive 1 then 3 → alloc_uid=3 first; m_id sequence follows the payload IDs of 3 then 1; two free_req pulses with ids 3 then 1.
- Backpressure: hold m_ready=0 for 10 cycles in SEND → m_valid and payload stable; free_req only after m_ready=1.
- Full FIFO: issue 16 UIDs → iss_ready=0; release one → iss_ready=1 exactly one cycle after pop.
- Protocol errors:
  - arr_valid for an unissued UID 7 → proto_err=1 next cycle, state unchanged.
  - Duplicate issue of a busy UID → proto_err=1.
- Reset in SEND: assert rst → m_valid=0, iss_ready=1, count=0 next cycle; no free_req observed.
- With ROB_RELEASE_TIMEOUT_EN and TIMEOUT_CYCLES=8: withhold pk_valid → timeout_err=1 after 8 REQ cycles, FSM returns to IDLE, then re-enters REQ for the same head.
